// File: rtl/signed_divider32_pkg.sv
// Shared types and constants for the 32-bit signed restoring divider.
// Also holds the magnitude helper used when operands are latched.
package div_pkg;

    localparam int DATA_W = 32;
    localparam int ITER_W = $clog2(DATA_W);

    localparam logic [DATA_W-1:0] DIV0_Q  = '1;
    localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Unsigned magnitude, so the most negative value maps to exactly 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/signed_divider32_if.sv
// Request/result bundle between the execute stage and the divider.
// Handshake: start is a one-cycle pulse honoured only while busy is low; done pulses once per accepted start.
interface signed_divider32_if
    import div_pkg::*;
();

    logic              start;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/signed_divider32_restore_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into R, then
// subtract D when it fits and record the quotient bit.
module div_restore_step
    import div_pkg::*;
(
    input  logic [DATA_W-1:0] r_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] r_o,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W:0] r_sh;
    logic [DATA_W:0] diff;
    logic            take;

    // R < D holds between steps, so a non-negative difference always fits in
    // DATA_W bits and the top bit of the wide difference is a clean borrow flag.
    always_comb begin
        r_sh = {r_i, q_i[DATA_W-1]};
        diff = r_sh - {1'b0, d_i};
        take = ~diff[DATA_W];
        r_o  = take ? diff[DATA_W-1:0] : r_sh[DATA_W-1:0];
        q_o  = {q_i[DATA_W-2:0], take};
    end

endmodule

// File: rtl/signed_divider32.sv
// Multi-cycle signed divider: magnitude pre-processing, 32 restoring steps,
// then sign fix-up with RISC-V divide-by-zero and overflow results.
module signed_divider32
    import div_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    signed_divider32_if.slave        bus,
    output state_e                   dbg_state
);

    state_e              state_q, state_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [DATA_W-1:0]   quo_acc_q, quo_acc_d;
    logic [DATA_W-1:0]   rem_acc_q, rem_acc_d;
    logic [DATA_W-1:0]   dvs_mag_q, dvs_mag_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic                quo_neg_q, quo_neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic                div0_q, div0_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;
    logic [DATA_W-1:0]   quotient_q, quotient_d;
    logic [DATA_W-1:0]   remainder_q, remainder_d;

    logic [DATA_W-1:0]   step_r;
    logic [DATA_W-1:0]   step_q;

    div_restore_step u_step (
        .r_i (rem_acc_q),
        .q_i (quo_acc_q),
        .d_i (dvs_mag_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        quo_acc_d   = quo_acc_q;
        rem_acc_d   = rem_acc_q;
        dvs_mag_d   = dvs_mag_q;
        dvd_d       = dvd_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        div0_d      = div0_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    quo_acc_d = abs_mag(bus.dividend);
                    dvs_mag_d = abs_mag(bus.divisor);
                    rem_acc_d = '0;
                    dvd_d     = bus.dividend;
                    quo_neg_d = bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1];
                    rem_neg_d = bus.dividend[DATA_W-1];
                    div0_d    = (bus.divisor == '0);
                    ovf_d     = (bus.dividend == INT_MIN) && (bus.divisor == DIV0_Q);
                    iter_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end
            end

            CALC: begin
                rem_acc_d = step_r;
                quo_acc_d = step_q;
                iter_d    = iter_q + 1'b1;
                if (iter_q == ITER_W'(DATA_W - 1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (div0_q) begin
                    quotient_d  = DIV0_Q;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                end else if (ovf_q) begin
                    quotient_d  = INT_MIN;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                end else begin
                    quotient_d  = quo_neg_q ? -quo_acc_q : quo_acc_q;
                    remainder_d = rem_neg_q ? -rem_acc_q : rem_acc_q;
                    dbz_d       = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            quo_acc_q   <= '0;
            rem_acc_q   <= '0;
            dvs_mag_q   <= '0;
            dvd_q       <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            quo_acc_q   <= quo_acc_d;
            rem_acc_q   <= rem_acc_d;
            dvs_mag_q   <= dvs_mag_d;
            dvd_q       <= dvd_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_signed_divider32.sv
// Directed and random checks of signed_divider32 against a plain-arithmetic
// reference, including latency, busy, reset abort and back-to-back issue.
module tb_signed_divider32;
    import div_pkg::*;

    // The start edge and the done edge are both counted in the 34-edge latency.
    localparam int LAT_EDGES = 33;
    localparam int N_RAND    = 2000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_e dbg_state;

    signed_divider32_if bus();

    signed_divider32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          edge_cnt = 0;
    bit          busy_ok;
    logic [31:0] last_q;

    vec_t dir_tab [11] = '{
        '{32'd10,          32'd3,          32'd3,            32'd1,          1'b0},
        '{-32'sd10,        32'd3,          -32'sd3,          -32'sd1,        1'b0},
        '{32'd10,          -32'sd3,        -32'sd3,          32'd1,          1'b0},
        '{-32'sd10,        -32'sd3,        32'd3,            -32'sd1,        1'b0},
        '{32'd0,           32'd3,          32'd0,            32'd0,          1'b0},
        '{32'd7,           32'd7,          32'd1,            32'd0,          1'b0},
        '{32'h7FFF_FFFF,   32'd1,          32'h7FFF_FFFF,    32'd0,          1'b0},
        '{32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,    32'd0,          1'b0},
        '{32'h8000_0000,   32'd2,          32'hC000_0000,    32'd0,          1'b0},
        '{-32'sd7,         32'd0,          32'hFFFF_FFFF,    -32'sd7,        1'b1},
        '{32'd7,           32'd0,          32'hFFFF_FFFF,    32'd7,          1'b1}
    };

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z);
        int sa;
        int sb;
        sa = a;
        sb = b;
        z  = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        edge_cnt     = 0;
        busy_ok      = bus.busy;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] eq,
                             input logic [31:0] er, input logic ez);
        while (!bus.done && edge_cnt < LAT_EDGES + 8) begin
            tick();
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end
        check({tag, ".latency"}, 32'(edge_cnt + 1), 32'(LAT_EDGES + 1));
        check({tag, ".busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, ".busy_low_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, ".q"}, bus.quotient, eq);
        check({tag, ".r"}, bus.remainder, er);
        check({tag, ".dbz"}, 32'(bus.div_by_zero), 32'(ez));
        last_q = eq;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rz;
        int          done_seen;
        int          sel;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.q", bus.quotient, 32'd0);
        check("rst.r", bus.remainder, 32'd0);
        check("rst.dbz", 32'(bus.div_by_zero), 32'd0);
        check("rst.state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        tick();

        // directed: each issue lands in the done cycle of the previous one
        for (int i = 0; i < 11; i++) begin
            issue(dir_tab[i].a, dir_tab[i].b);
            wait_done($sformatf("dir%0d", i), dir_tab[i].q, dir_tab[i].r, dir_tab[i].z);
        end

        // start while busy is ignored; results held until the next done
        tick();
        issue(32'd1000, -32'sd7);
        repeat (5) tick();
        check("hold.q", bus.quotient, last_q);
        check("hold.dbz", 32'(bus.div_by_zero), 32'd1);
        bus.start    = 1'b1;
        bus.dividend = 32'd5;
        bus.divisor  = 32'd5;
        tick();
        bus.start    = 1'b0;
        wait_done("busy_start", -32'sd142, 32'd6, 1'b0);
        tick();
        check("idle_after_busy_start.done", 32'(bus.done), 32'd0);

        // leave non-zero results so the abort visibly clears them
        issue(32'd9, 32'd0);
        wait_done("pre_abort", 32'hFFFF_FFFF, 32'd9, 1'b1);
        issue(32'd100, 32'd7);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        check("abort.q", bus.quotient, 32'd0);
        check("abort.r", bus.remainder, 32'd0);
        check("abort.dbz", 32'(bus.div_by_zero), 32'd0);
        check("abort.state", 32'(dbg_state), 32'(IDLE));
        repeat (2) tick();
        rst_n = 1'b1;
        done_seen = 0;
        repeat (LAT_EDGES + 8) begin
            tick();
            if (bus.done) done_seen++;
        end
        check("abort.no_done", 32'(done_seen), 32'd0);

        // random signed pairs with edge-value bias
        for (int n = 0; n < N_RAND; n++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = $urandom;
            case (sel)
                0: rb = 32'd0;
                1: begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
                2: rb = 32'($signed(8'($urandom)));
                3: ra = 32'($signed(12'($urandom)));
                4: ra = 32'h8000_0000;
                default: ;
            endcase
            ref_div(ra, rb, rq, rr, rz);
            issue(ra, rb);
            wait_done($sformatf("rnd%0d a=%h b=%h", n, ra, rb), rq, rr, rz);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
